// File: rtl/dynamic_fifo_ctrl.sv
// dynamic_fifo_ctrl: pointer/occupancy controller that turns an external simple dual-port RAM
// into a FIFO whose depth, almost-full and almost-empty thresholds can be changed at run time.
// Depth changes with data present go through a DRAIN state that blocks pushes until empty.
// Optional feature macro: DYNFIFO_STALL_STATS_EN adds saturating push/pop stall counters.
module dynamic_fifo_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_valid_i,
    output logic                  push_ready_o,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    output logic                  pop_valid_o,
    input  logic                  pop_ready_i,
    output logic [DATA_WIDTH-1:0] pop_data_o,
    input  logic [ADDR_WIDTH:0]   cfg_depth_i,
    input  logic [ADDR_WIDTH:0]   cfg_af_i,
    input  logic [ADDR_WIDTH:0]   cfg_ae_i,
    input  logic                  cfg_load_i,
    output logic                  cfg_busy_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_waddr_o,
    output logic [DATA_WIDTH-1:0] ram_wdata_o,
    output logic                  ram_re_o,
    output logic [ADDR_WIDTH-1:0] ram_raddr_o,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i
`ifdef DYNFIFO_STALL_STATS_EN
    ,
    input  logic                  stat_clear_i,
    output logic [15:0]           push_stall_cnt_o,
    output logic [15:0]           pop_stall_cnt_o
`endif
);

    localparam logic [ADDR_WIDTH:0] MaxDepth = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] AfReset  = {1'b0, {ADDR_WIDTH{1'b1}}};
    localparam logic [ADDR_WIDTH:0] AeReset  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [0:0] {StRun, StDrain} state_e;

    state_e                state_q;
    logic                  cfg_busy_q;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH:0]   depth_q, af_q, ae_q;
    logic [ADDR_WIDTH:0]   sh_depth_q, sh_af_q, sh_ae_q;
    logic                  push_fire, pop_fire;

    // Zero or oversized depth requests fall back to the full RAM.
    function automatic logic [ADDR_WIDTH:0] clamp_depth(input logic [ADDR_WIDTH:0] d);
        if (d == '0 || d > MaxDepth) return MaxDepth;
        return d;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p,
                                                      input logic [ADDR_WIDTH:0]   d);
        if ({1'b0, p} == d - 1'b1) return '0;
        return p + 1'b1;
    endfunction

    assign full_o         = (count_q == depth_q);
    assign empty_o        = (count_q == '0);
    assign almost_full_o  = (count_q >= af_q);
    assign almost_empty_o = (count_q <= ae_q);
    assign count_o        = count_q;
    assign cfg_busy_o     = cfg_busy_q;
    assign pop_valid_o    = !empty_o;
    assign push_ready_o   = !full_o && (state_q == StRun);
    assign push_fire      = push_valid_i && push_ready_o;
    assign pop_fire       = pop_valid_o && pop_ready_i;

    assign ram_we_o    = push_fire;
    assign ram_waddr_o = wr_ptr_q;
    assign ram_wdata_o = push_data_i;
    assign ram_re_o    = pop_valid_o;
    assign ram_raddr_o = rd_ptr_q;
    assign pop_data_o  = ram_rdata_i;

    // Normal-operation pointer and occupancy update, before any config override.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_fire) wr_ptr_d = ptr_inc(wr_ptr_q, depth_q);
        if (pop_fire)  rd_ptr_d = ptr_inc(rd_ptr_q, depth_q);
        unique case ({push_fire, pop_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Run/drain FSM; applying a config clears pointers and count (a push coinciding
    // with an immediate apply is discarded along with the old layout).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRun;
            cfg_busy_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            depth_q    <= MaxDepth;
            af_q       <= AfReset;
            ae_q       <= AeReset;
            sh_depth_q <= MaxDepth;
            sh_af_q    <= AfReset;
            sh_ae_q    <= AeReset;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            unique case (state_q)
                StRun: begin
                    if (cfg_load_i) begin
                        if (count_q == '0) begin
                            depth_q  <= clamp_depth(cfg_depth_i);
                            af_q     <= cfg_af_i;
                            ae_q     <= cfg_ae_i;
                            wr_ptr_q <= '0;
                            rd_ptr_q <= '0;
                            count_q  <= '0;
                        end else begin
                            sh_depth_q <= clamp_depth(cfg_depth_i);
                            sh_af_q    <= cfg_af_i;
                            sh_ae_q    <= cfg_ae_i;
                            state_q    <= StDrain;
                            cfg_busy_q <= 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (count_q == '0) begin
                        depth_q    <= sh_depth_q;
                        af_q       <= sh_af_q;
                        ae_q       <= sh_ae_q;
                        wr_ptr_q   <= '0;
                        rd_ptr_q   <= '0;
                        state_q    <= StRun;
                        cfg_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= StRun;
                    cfg_busy_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef DYNFIFO_STALL_STATS_EN
    logic [15:0] push_stall_q, pop_stall_q;

    // Saturating stall counters; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_stall_q <= '0;
            pop_stall_q  <= '0;
        end else if (stat_clear_i) begin
            push_stall_q <= '0;
            pop_stall_q  <= '0;
        end else begin
            if (push_valid_i && !push_ready_o && push_stall_q != 16'hFFFF) begin
                push_stall_q <= push_stall_q + 16'd1;
            end
            if (pop_ready_i && !pop_valid_o && pop_stall_q != 16'hFFFF) begin
                pop_stall_q <= pop_stall_q + 16'd1;
            end
        end
    end

    assign push_stall_cnt_o = push_stall_q;
    assign pop_stall_cnt_o  = pop_stall_q;
`endif

endmodule

// File: tb/tb_dynamic_fifo_ctrl.sv
// Self-checking bench for dynamic_fifo_ctrl: drives directed and random traffic and compares
// every cycle against a queue-based FIFO model. Define DYNFIFO_STALL_STATS_EN to cover stats.
module tb_dynamic_fifo_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          push_valid, push_ready, pop_valid, pop_ready;
    logic [DW-1:0] push_data, pop_data;
    logic [AW:0]   cfg_depth, cfg_af, cfg_ae, count;
    logic          cfg_load, cfg_busy, full, empty, almost_full, almost_empty;
    logic          ram_we, ram_re;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic [DW-1:0] ram_wdata, ram_rdata;
`ifdef DYNFIFO_STALL_STATS_EN
    logic          stat_clear;
    logic [15:0]   push_stall_cnt, pop_stall_cnt;
    int            m_pstall, m_qstall;
`endif

    always #5 clk = ~clk;

    dynamic_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .push_valid_i   (push_valid),
        .push_ready_o   (push_ready),
        .push_data_i    (push_data),
        .pop_valid_o    (pop_valid),
        .pop_ready_i    (pop_ready),
        .pop_data_o     (pop_data),
        .cfg_depth_i    (cfg_depth),
        .cfg_af_i       (cfg_af),
        .cfg_ae_i       (cfg_ae),
        .cfg_load_i     (cfg_load),
        .cfg_busy_o     (cfg_busy),
        .count_o        (count),
        .full_o         (full),
        .empty_o        (empty),
        .almost_full_o  (almost_full),
        .almost_empty_o (almost_empty),
        .ram_we_o       (ram_we),
        .ram_waddr_o    (ram_waddr),
        .ram_wdata_o    (ram_wdata),
        .ram_re_o       (ram_re),
        .ram_raddr_o    (ram_raddr),
        .ram_rdata_i    (ram_rdata)
`ifdef DYNFIFO_STALL_STATS_EN
        ,
        .stat_clear_i     (stat_clear),
        .push_stall_cnt_o (push_stall_cnt),
        .pop_stall_cnt_o  (pop_stall_cnt)
`endif
    );

    // Simple dual-port RAM: synchronous write, asynchronous read.
    logic [DW-1:0] mem [16];
    always @(posedge clk) if (ram_we) mem[ram_waddr] <= ram_wdata;
    assign ram_rdata = mem[ram_raddr];

    // Reference model state.
    int q[$];
    int m_depth, m_af, m_ae, m_busy, s_depth, s_af, s_ae, m_wr, m_rd;
    int vectors = 0;
    int errors  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int clampd(input int d);
        return (d == 0 || d > 16) ? 16 : d;
    endfunction

    task automatic model_reset();
        q.delete();
        m_depth = 16; m_af = 15; m_ae = 1; m_busy = 0;
        s_depth = 16; s_af = 15; s_ae = 1; m_wr = 0; m_rd = 0;
`ifdef DYNFIFO_STALL_STATS_EN
        m_pstall = 0; m_qstall = 0;
`endif
    endtask

    task automatic check_all();
        int sz;
        int pready;
        sz     = q.size();
        pready = (sz < m_depth && m_busy == 0) ? 1 : 0;
        check("count", count, sz);
        check("full", full, sz == m_depth);
        check("empty", empty, sz == 0);
        check("almost_full", almost_full, sz >= m_af);
        check("almost_empty", almost_empty, sz <= m_ae);
        check("push_ready", push_ready, pready);
        check("pop_valid", pop_valid, sz > 0);
        check("ram_re", ram_re, sz > 0);
        check("cfg_busy", cfg_busy, m_busy);
        check("ram_we", ram_we, push_valid && pready != 0);
        check("ram_waddr", ram_waddr, m_wr);
        check("ram_raddr", ram_raddr, m_rd);
        if (push_valid && pready != 0) check("ram_wdata", ram_wdata, push_data);
        if (sz > 0) check("pop_data", pop_data, q[0]);
`ifdef DYNFIFO_STALL_STATS_EN
        check("push_stall_cnt", push_stall_cnt, m_pstall);
        check("pop_stall_cnt", pop_stall_cnt, m_qstall);
`endif
    endtask

    // One clock cycle: drive, check pre-edge outputs, then advance the model at the edge.
    task automatic step(input logic pv, input int pd, input logic pr,
                        input logic ld, input int d, input int af, input int ae);
        int  sz0;
        bit  pf, qf, pready;
        @(negedge clk);
        push_valid = pv;
        push_data  = pd[7:0];
        pop_ready  = pr;
        cfg_load   = ld;
        cfg_depth  = d[4:0];
        cfg_af     = af[4:0];
        cfg_ae     = ae[4:0];
        #1 check_all();
        sz0    = q.size();
        pready = (sz0 < m_depth && m_busy == 0);
        pf     = pv && pready;
        qf     = pr && sz0 > 0;
        @(posedge clk);
`ifdef DYNFIFO_STALL_STATS_EN
        if (stat_clear) begin
            m_pstall = 0; m_qstall = 0;
        end else begin
            if (pv && !pready && m_pstall < 65535) m_pstall++;
            if (pr && sz0 == 0 && m_qstall < 65535) m_qstall++;
        end
`endif
        if (qf) begin
            void'(q.pop_front());
            m_rd = (m_rd + 1) % m_depth;
        end
        if (pf) begin
            q.push_back(pd & 8'hFF);
            m_wr = (m_wr + 1) % m_depth;
        end
        if (m_busy == 0 && ld) begin
            if (sz0 == 0) begin
                m_depth = clampd(d & 31); m_af = af & 31; m_ae = ae & 31;
                q.delete(); m_wr = 0; m_rd = 0;
            end else begin
                s_depth = clampd(d & 31); s_af = af & 31; s_ae = ae & 31;
                m_busy = 1;
            end
        end else if (m_busy != 0 && sz0 == 0) begin
            m_depth = s_depth; m_af = s_af; m_ae = s_ae;
            m_wr = 0; m_rd = 0; m_busy = 0;
        end
    endtask

    task automatic drain_all();
        repeat (40) step(1'b0, 0, 1'b1, 1'b0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        push_valid = 1'b0; push_data = '0; pop_ready = 1'b0;
        cfg_load = 1'b0; cfg_depth = '0; cfg_af = '0; cfg_ae = '0;
`ifdef DYNFIFO_STALL_STATS_EN
        stat_clear = 1'b0;
`endif
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_push_ready", push_ready, 1);
        check("rst_pop_valid", pop_valid, 0);
        check("rst_empty", empty, 1);
        check("rst_almost_empty", almost_empty, 1);
        check("rst_full", full, 0);
        check("rst_almost_full", almost_full, 0);
        check("rst_cfg_busy", cfg_busy, 0);
        check("rst_count", count, 0);

        // Fill the full 16-deep FIFO, try one extra push, then empty it in order.
        for (int i = 0; i < 16; i++) step(1'b1, i, 1'b0, 1'b0, 0, 0, 0);
        step(1'b1, 8'hAA, 1'b0, 1'b0, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(1'b0, 0, 1'b1, 1'b0, 0, 0, 0);
        step(1'b0, 0, 1'b0, 1'b0, 0, 0, 0);

        // Depth 5 applied while empty; 7 pushes, only 5 accepted; then interleave.
        step(1'b0, 0, 1'b0, 1'b1, 5, 4, 1);
        for (int i = 0; i < 7; i++) step(1'b1, 8'h20 + i, 1'b0, 1'b0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(i % 3 != 0, 8'h40 + i, 1'b1, 1'b0, 0, 0, 0);
        drain_all();

        // Depth change with 3 entries queued goes through drain.
        for (int i = 0; i < 3; i++) step(1'b1, 8'h60 + i, 1'b0, 1'b0, 0, 0, 0);
        step(1'b0, 0, 1'b0, 1'b1, 8, 6, 2);
        step(1'b1, 8'hEE, 1'b0, 1'b1, 2, 1, 1);
        for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1, 1'b0, 0, 0, 0);
        step(1'b0, 0, 1'b0, 1'b0, 0, 0, 0);
        for (int i = 0; i < 9; i++) step(1'b1, 8'h70 + i, 1'b0, 1'b0, 0, 0, 0);
        drain_all();

        // Steady-state simultaneous push and pop at count 2.
        for (int i = 0; i < 2; i++) step(1'b1, 8'h80 + i, 1'b0, 1'b0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(1'b1, 8'h90 + i, 1'b1, 1'b0, 0, 0, 0);
        drain_all();

        // Random traffic with occasional (possibly clamped) reconfiguration.
        for (int i = 0; i < 800; i++) begin
            logic ld;
            ld = ($urandom_range(0, 39) == 0);
            step(ld ? 1'b0 : ($urandom_range(0, 3) != 0), $urandom_range(0, 255),
                 ($urandom_range(0, 2) == 0), ld, $urandom_range(0, 31),
                 $urandom_range(0, 20), $urandom_range(0, 20));
        end
        drain_all();
        step(1'b0, 0, 1'b0, 1'b1, 16, 15, 1);

`ifdef DYNFIFO_STALL_STATS_EN
        @(negedge clk); stat_clear = 1'b1;
        step(1'b0, 0, 1'b0, 1'b0, 0, 0, 0);
        stat_clear = 1'b0;
        for (int i = 0; i < 16; i++) step(1'b1, i, 1'b0, 1'b0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1'b1, 8'hBB, 1'b0, 1'b0, 0, 0, 0);
        step(1'b0, 0, 1'b0, 1'b0, 0, 0, 0);
        check("push_stall_4", push_stall_cnt, 4);
        stat_clear = 1'b1;
        step(1'b0, 0, 1'b0, 1'b0, 0, 0, 0);
        stat_clear = 1'b0;
        step(1'b0, 0, 1'b0, 1'b0, 0, 0, 0);
        check("push_stall_clr", push_stall_cnt, 0);
        drain_all();
        step(1'b0, 0, 1'b0, 1'b1, 16, 15, 1);
`endif

        // Reset in the middle of a drain discards the pending configuration.
        for (int i = 0; i < 3; i++) step(1'b1, 8'hC0 + i, 1'b0, 1'b0, 0, 0, 0);
        step(1'b0, 0, 1'b0, 1'b1, 8, 6, 2);
        step(1'b0, 0, 1'b1, 1'b0, 0, 0, 0);
        @(negedge clk);
        push_valid = 1'b0; pop_ready = 1'b0; cfg_load = 1'b0;
        check("pre_rst_busy", cfg_busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_count", count, 0);
        check("mid_rst_busy", cfg_busy, 0);
        check("mid_rst_push_ready", push_ready, 1);
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 17; i++) step(1'b1, 8'hD0 + i, 1'b0, 1'b0, 0, 0, 0);
        drain_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
